mem_arbiter: RTL and testbench

Two-port memory arbiter for the LC-3 system. It shares the single memory array between the CPU datapath port (driven by the control unit's MIO_EN/R_W and MAR/MDR) and a DMA/loader port. It sequences each access through a fixed wait-state count and returns a one-cycle ready pulse, the R signal, to the requester that owns the access. It sits between the datapath/loader and the memory array and replaces the direct MIO_EN→memory connection.

---
 rtl/mem_arbiter_if.sv | 23 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// One requester port of the LC-3 memory arbiter.
// The requester drives master; the arbiter receives it as slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output req, rw, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, rw, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter between the LC-3 CPU datapath and the DMA/loader.
// Each access runs a fixed number of array cycles, then pulses ready to its owner.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dma,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              grant_o,
  output logic              busy_o
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_q, grant_d;
  logic              lastGrant_q, lastGrant_d;
  logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
  logic [DATA_W-1:0] dmaRdata_q, dmaRdata_d;
  logic              cpuReady_q, cpuReady_d;
  logic              dmaReady_q, dmaReady_d;
  logic              winner;

  // lastGrant resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      cpuRdata_q  <= '0;
      dmaRdata_q  <= '0;
      cpuReady_q  <= 1'b0;
      dmaReady_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      cpuRdata_q  <= cpuRdata_d;
      dmaRdata_q  <= dmaRdata_d;
      cpuReady_q  <= cpuReady_d;
      dmaReady_q  <= dmaReady_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    cpuRdata_d  = cpuRdata_q;
    dmaRdata_d  = dmaRdata_q;
    cpuReady_d  = 1'b0;
    dmaReady_d  = 1'b0;
    winner      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu.req || dma.req) begin
          // DMA wins when alone, or on a tie when the CPU had the last grant.
          winner      = dma.req && (!cpu.req || !lastGrant_q);
          rw_d        = winner ? dma.rw    : cpu.rw;
          addr_d      = winner ? dma.addr  : cpu.addr;
          wdata_d     = winner ? dma.wdata : cpu.wdata;
          cnt_d       = CNT_LOAD;
          grant_d     = winner;
          lastGrant_d = winner;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (grant_q) begin
            dmaReady_d = 1'b1;
            if (!rw_q) dmaRdata_d = mem_rdata_i;
          end else begin
            cpuReady_d = 1'b1;
            if (!rw_q) cpuRdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array strobes come straight from the state register so reset removes them at once.
  assign mem_en_o    = (state_q == ACCESS);
  assign mem_we_o    = (state_q == ACCESS) && rw_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);

  assign cpu.rdata = cpuRdata_q;
  assign cpu.ready = cpuReady_q;
  assign dma.rdata = dmaRdata_q;
  assign dma.ready = dmaReady_q;

  readyExclusive: assert property (@(posedge clk_i) disable iff (reset_i)
    !(cpuReady_q && dmaReady_q));

  readyOnlyInDone: assert property (@(posedge clk_i) disable iff (reset_i)
    (cpuReady_q || dmaReady_q) |-> (state_q == DONE));

  doneReturnsIdle: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == DONE) |=> (state_q == IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: a behavioural memory array behind the arbiter,
// with expected ready pulses (port, cycle, rdata) queued as requests are issued.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  typedef struct {
    bit          isDma;
    int          cycle;
    logic [15:0] data;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic        memEn, memWe;
  logic [15:0] memAddr, memWdata, memRdata;
  logic        grant, busy;

  logic        preEn = 1'b0;
  logic [15:0] preAddr = '0;
  logic [15:0] preData = '0;
  logic [15:0] memArr [0:65535];

  int          cycleCnt = 0;
  int          assertCount = 0;
  int          failCount = 0;
  expT         expQ [$];
  logic [15:0] cpuModel, dmaModel;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpuIf ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dmaIf ();

  mem_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .cpu        (cpuIf),
    .dma        (dmaIf),
    .mem_en_o   (memEn),
    .mem_we_o   (memWe),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Behavioural array: combinational read, write on the clock edge while enabled.
  always @(posedge clk) begin
    if (preEn) memArr[preAddr] <= preData;
    else if (memEn && memWe) memArr[memAddr] <= memWdata;
  end

  assign memRdata = memArr[memAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleCnt);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isDma, input bit req, input bit rw,
                               input logic [15:0] addr, input logic [15:0] wdata);
    if (isDma) begin
      dmaIf.req = req; dmaIf.rw = rw; dmaIf.addr = addr; dmaIf.wdata = wdata;
    end else begin
      cpuIf.req = req; cpuIf.rw = rw; cpuIf.addr = addr; cpuIf.wdata = wdata;
    end
  endtask

  task automatic preload(input logic [15:0] addr, input logic [15:0] data);
    preEn = 1'b1; preAddr = addr; preData = data;
    waitCycles(1);
    preEn = 1'b0;
  endtask

  task automatic pushExp(input bit isDma, input int cycle, input logic [15:0] data);
    expT e;
    e.isDma = isDma; e.cycle = cycle; e.data = data;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    cpuModel = '0;
    dmaModel = '0;
    waitCycles(1);
  endtask

  // One complete single-requester access with per-cycle checks of the array side.
  task automatic doAccess(input bit isDma, input bit rw, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] readData);
    logic [15:0] expData;
    if (rw) expData = isDma ? dmaModel : cpuModel;
    else begin
      expData = readData;
      if (isDma) dmaModel = readData; else cpuModel = readData;
    end
    pushExp(isDma, cycleCnt + MEM_LAT + 1, expData);
    applyStimulus(isDma, 1'b1, rw, addr, wdata);
    for (int k = 1; k <= MEM_LAT; k++) begin
      waitCycles(1);
      checkOutput("accessEn", memEn, 1);
      checkOutput("accessWe", memWe, rw);
      checkOutput("accessAddr", memAddr, addr);
      if (rw) checkOutput("accessWdata", memWdata, wdata);
      checkOutput("accessGrant", grant, isDma);
    end
    waitCycles(1);
    checkOutput("doneEn", memEn, 0);
    checkOutput("doneBusy", busy, 1);
    applyStimulus(isDma, 1'b0, rw, addr, wdata);
    waitCycles(1);
    checkOutput("idleBusy", busy, 0);
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  task automatic monitorReady();
    expT e;
    forever begin
      @(negedge clk);
      if (!reset && (cpuIf.ready || dmaIf.ready)) begin
        checkOutput("dualReady", cpuIf.ready & dmaIf.ready, 0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedReady", {cpuIf.ready, dmaIf.ready}, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("readyPort", dmaIf.ready, e.isDma);
          checkOutput("readyCycle", cycleCnt, e.cycle);
          checkOutput("rdata", e.isDma ? dmaIf.rdata : cpuIf.rdata, e.data);
        end
      end
    end
  endtask

  initial begin
    int c;
    reset = 1'b1;
    cpuModel = '0;
    dmaModel = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    fork
      monitorReady();
    join_none

    waitCycles(1);
    preload(16'h3000, 16'h1234);
    preload(16'h5000, 16'hA5A5);
    preload(16'h5001, 16'h5A5A);
    preload(16'h6000, 16'h0000);

    checkOutput("rstMemEn", memEn, 0);
    checkOutput("rstMemWe", memWe, 0);
    checkOutput("rstMemAddr", memAddr, 0);
    checkOutput("rstMemWdata", memWdata, 0);
    checkOutput("rstCpuRdata", cpuIf.rdata, 0);
    checkOutput("rstDmaRdata", dmaIf.rdata, 0);
    checkOutput("rstCpuReady", cpuIf.ready, 0);
    checkOutput("rstDmaReady", dmaIf.ready, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstGrant", grant, 0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] CPU read, CPU write, DMA read");
    doAccess(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234);
    doAccess(1'b0, 1'b1, 16'h4000, 16'hBEEF, 16'h0000);
    checkOutput("writeCommit", memArr[16'h4000], 16'hBEEF);
    doAccess(1'b1, 1'b0, 16'h4000, 16'h0000, 16'hBEEF);
    checkOutput("cpuRdataHeld", cpuIf.rdata, 16'h1234);

    $display("[TB] simultaneous requests from reset");
    doReset();
    c = cycleCnt;
    pushExp(1'b0, c + 3, 16'hA5A5);
    pushExp(1'b1, c + 7, 16'h5A5A);
    pushExp(1'b0, c + 11, 16'hA5A5);
    pushExp(1'b1, c + 15, 16'h5A5A);
    cpuModel = 16'hA5A5;
    dmaModel = 16'h5A5A;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h5000, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h5001, 16'h0);
    for (int i = 0; i < 4; i++) begin
      waitCycles(i == 0 ? 1 : 4);
      checkOutput("rrGrant", grant, i % 2);
      checkOutput("rrAddr", memAddr, (i % 2) ? 16'h5001 : 16'h5000);
    end
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h5000, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h5001, 16'h0);
    waitCycles(1);
    checkOutput("rrIdle", busy, 0);

    $display("[TB] DMA request during CPU access");
    c = cycleCnt;
    pushExp(1'b0, c + 3, 16'h1234);
    pushExp(1'b1, c + 7, 16'hBEEF);
    cpuModel = 16'h1234;
    dmaModel = 16'hBEEF;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4000, 16'h0);
    waitCycles(1);
    checkOutput("lateGrantCpu", grant, 0);
    checkOutput("lateAddrCpu", memAddr, 16'h3000);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0);
    waitCycles(2);
    checkOutput("lateGrantDma", grant, 1);
    checkOutput("lateAddrDma", memAddr, 16'h4000);
    waitCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4000, 16'h0);
    waitCycles(1);
    checkOutput("lateIdle", busy, 0);

    $display("[TB] inputs change and request drops mid-write");
    c = cycleCnt;
    pushExp(1'b0, c + 3, cpuModel);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h6000, 16'h1111);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h7000, 16'h2222);
    #1;
    checkOutput("latchAddr", memAddr, 16'h6000);
    checkOutput("latchWdata", memWdata, 16'h1111);
    checkOutput("latchWe", memWe, 1);
    waitCycles(1);
    checkOutput("latchAddr2", memAddr, 16'h6000);
    checkOutput("latchEn2", memEn, 1);
    waitCycles(3);
    checkOutput("dropIdle", busy, 0);
    checkOutput("dropCommit", memArr[16'h6000], 16'h1111);

    $display("[TB] reset during access");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0);
    waitCycles(2);
    checkOutput("preRstEn", memEn, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstEn", memEn, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstReady", cpuIf.ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0);
    cpuModel = '0;
    dmaModel = '0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(3);
    checkOutput("postRstRdata", cpuIf.rdata, 0);
    doAccess(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234);

    waitCycles(5);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
